round_timer: RTL and testbench



---
 rtl/rally_pkg.sv | 28 ++
 rtl/round_timer_if.sv | 25 ++
 rtl/sec_prescaler.sv | 29 ++
 rtl/round_timer.sv | 170 +++++++++++++++++
 tb/tb_round_timer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rally_pkg.sv
// Shared rally game types and constants.
// Level encodings are common to the game-state FSM and the round timer.
package rally_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    localparam int MAX_SECS = 99;

    // Splits a 0..99 value into {tens, ones}; used on constants only.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 7'd10);
        o = 4'(v % 7'd10);
        return {t, o};
    endfunction

endpackage

// File: rtl/round_timer_if.sv
// Control/status bundle between the game-state FSM and the round timer.
// master = game FSM / HUD side, slave = timer.
interface round_timer_if;
    logic       game_active;
    logic [1:0] level_id;
    logic       pause;
    logic       time_out;
    logic [6:0] secs_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       sec_tick;
    logic       warn;

    modport master (
        output game_active, level_id, pause,
        input  time_out, secs_left, bcd_tens,
        input  bcd_ones, sec_tick, warn
    );

    modport slave (
        input  game_active, level_id, pause,
        output time_out, secs_left, bcd_tens,
        output bcd_ones, sec_tick, warn
    );
endinterface

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-second enable.
// tick is high on the enabled terminal-count cycle.
module sec_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] TC = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = en && (cnt_q == TC);

    // Count enabled cycles, wrap at terminal count, hold when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/round_timer.sv
// Per-round countdown: loads a level limit, counts seconds down,
// raises time_out at zero and exports binary + BCD remaining time.
module round_timer
    import rally_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int L1_SECS   = 60,
    parameter int L2_SECS   = 45,
    parameter int L3_SECS   = 30,
    parameter int WARN_SECS = 10
) (
    input  logic          clk,
    input  logic          rst,
    round_timer_if.slave  bus
);
    localparam logic [6:0] LIM1 = 7'(L1_SECS);
    localparam logic [6:0] LIM2 = 7'(L2_SECS);
    localparam logic [6:0] LIM3 = 7'(L3_SECS);
    localparam logic [6:0] WLIM = 7'(WARN_SECS);
    localparam logic [7:0] BCD1 = bin2bcd(LIM1);
    localparam logic [7:0] BCD2 = bin2bcd(LIM2);
    localparam logic [7:0] BCD3 = bin2bcd(LIM3);

    timer_state_t state_q;
    timer_state_t state_d;

    logic [1:0] lvl_q;
    logic [6:0] secs_q;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       to_q;
    logic       stick_q;

    logic [6:0] lim;
    logic [7:0] lim_bcd;
    logic       tick;
    logic       pre_en;
    logic       pre_clr;

    assign pre_en  = (state_q == RUN) && bus.game_active
                     && !bus.pause;
    assign pre_clr = (state_q == LOAD);

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (tick)
    );

    // Limit mux for the level captured when the round was started.
    always_comb begin
        lim     = '0;
        lim_bcd = '0;
        unique case (lvl_q)
            LVL_1: begin
                lim     = LIM1;
                lim_bcd = BCD1;
            end
            LVL_2: begin
                lim     = LIM2;
                lim_bcd = BCD2;
            end
            LVL_3: begin
                lim     = LIM3;
                lim_bcd = BCD3;
            end
            default: begin
                lim     = '0;
                lim_bcd = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a falling game_active always wins over a tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.game_active && bus.level_id != LVL_NONE)
                    state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (!bus.game_active)
                    state_d = IDLE;
                else if (tick && secs_q == 7'd1)
                    state_d = EXPIRED;
            end
            EXPIRED: begin
                if (!bus.game_active)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Binary/BCD down-counter, time_out and tick pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= LVL_NONE;
            secs_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            to_q    <= 1'b0;
            stick_q <= 1'b0;
        end else begin
            stick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.game_active && bus.level_id != LVL_NONE)
                        lvl_q <= bus.level_id;
                end
                LOAD: begin
                    secs_q <= lim;
                    tens_q <= lim_bcd[7:4];
                    ones_q <= lim_bcd[3:0];
                    to_q   <= 1'b0;
                end
                RUN: begin
                    if (tick && secs_q != 7'd0) begin
                        stick_q <= 1'b1;
                        secs_q  <= secs_q - 7'd1;
                        if (ones_q == 4'd0) begin
                            ones_q <= 4'd9;
                            tens_q <= tens_q - 4'd1;
                        end else begin
                            ones_q <= ones_q - 4'd1;
                        end
                        if (secs_q == 7'd1)
                            to_q <= 1'b1;
                    end
                end
                EXPIRED: begin
                    secs_q <= '0;
                    tens_q <= '0;
                    ones_q <= '0;
                    to_q   <= bus.game_active;
                end
                default: begin
                    to_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.secs_left = secs_q;
    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_ones  = ones_q;
    assign bus.time_out  = to_q;
    assign bus.sec_tick  = stick_q;
    assign bus.warn      = (state_q == RUN) && (secs_q != 7'd0)
                           && (secs_q <= WLIM);
endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer.
// Directed scenarios followed by a randomized phase against a round model.
module tb_round_timer;
    localparam int TICK = 4;
    localparam int WARN = 2;

    logic clk;
    logic rst;
    logic ga;
    logic [1:0] lvl;
    logic pz;

    int n_chk;
    int n_fail;

    int lim [0:3] = '{0, 3, 12, 1};

    // model: mode 0 waiting, 1 starting, 2 counting, 3 timed out
    int m_mode;
    int m_pend;
    int m_secs;
    int m_acc;
    bit m_to;
    bit m_tick;

    round_timer_if bus ();

    assign bus.game_active = ga;
    assign bus.level_id    = lvl;
    assign bus.pause       = pz;

    round_timer #(
        .TICK_DIV  (TICK),
        .L1_SECS   (3),
        .L2_SECS   (12),
        .L3_SECS   (1),
        .WARN_SECS (WARN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pend = 0;
        m_secs = 0;
        m_acc  = 0;
        m_to   = 0;
        m_tick = 0;
    endtask

    task automatic model_update();
        m_tick = 0;
        case (m_mode)
            0: if (ga && lvl != 0) begin
                m_pend = int'(lvl);
                m_mode = 1;
            end
            1: begin
                m_secs = lim[m_pend];
                m_acc  = 0;
                m_to   = 0;
                m_mode = 2;
            end
            2: if (!ga) begin
                m_mode = 0;
            end else if (!pz) begin
                m_acc++;
                if (m_acc == TICK) begin
                    m_acc  = 0;
                    m_secs = m_secs - 1;
                    m_tick = 1;
                    if (m_secs == 0) begin
                        m_mode = 3;
                        m_to   = 1;
                    end
                end
            end
            default: begin
                m_secs = 0;
                if (!ga) begin
                    m_mode = 0;
                    m_to   = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        bit w;
        w = (m_mode == 2) && (m_secs > 0) && (m_secs <= WARN);
        chk("secs_left", 8'(bus.secs_left), 8'(m_secs));
        chk("bcd_tens", 8'(bus.bcd_tens), 8'(m_secs / 10));
        chk("bcd_ones", 8'(bus.bcd_ones), 8'(m_secs % 10));
        chk("time_out", 8'(bus.time_out), 8'(m_to));
        chk("sec_tick", 8'(bus.sec_tick), 8'(m_tick));
        chk("warn", 8'(bus.warn), 8'(w));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        ga  = 1'b0;
        lvl = 2'd0;
        pz  = 1'b0;
        model_reset();
        #1;
        check_all();
        steps(2);
        rst = 1'b0;
        steps(2);

        // Level 1: 3 -> 2 -> 1 -> 0, then release
        lvl = 2'd1;
        ga  = 1'b1;
        steps(2);
        chk("l1_loaded", 8'(bus.secs_left), 8'd3);
        steps(3 * TICK + 2);
        chk("l1_expired", 8'(bus.time_out), 8'd1);
        ga = 1'b0;
        steps(2);
        chk("l1_release", 8'(bus.time_out), 8'd0);

        // Level 2: BCD borrow 12 -> 11 -> 10 -> 9 -> 8
        lvl = 2'd2;
        ga  = 1'b1;
        steps(2 + 3 * TICK);
        chk("bcd_at_9_tens", 8'(bus.bcd_tens), 8'd0);
        chk("bcd_at_9_ones", 8'(bus.bcd_ones), 8'd9);
        steps(2);
        // Pause mid-second
        pz = 1'b1;
        steps(10);
        pz = 1'b0;
        steps(2 * TICK);
        ga = 1'b0;
        steps(2);

        // Early exit at 2, then restart on level 3
        lvl = 2'd1;
        ga  = 1'b1;
        for (int i = 0; i < 40 && !(m_mode == 2 && m_secs == 2); i++)
            step();
        chk("reach_two", 8'(m_secs), 8'd2);
        ga = 1'b0;
        steps(3);
        chk("early_hold", 8'(bus.secs_left), 8'd2);
        lvl = 2'd3;
        ga  = 1'b1;
        steps(2);
        chk("l3_loaded", 8'(bus.secs_left), 8'd1);
        steps(TICK);
        chk("l3_timeout", 8'(bus.time_out), 8'd1);
        ga = 1'b0;
        steps(2);

        // Drop game_active exactly on the final terminal count
        lvl = 2'd1;
        ga  = 1'b1;
        for (int i = 0; i < 40 && !(m_secs == 1 && m_acc == TICK - 1
                                    && m_mode == 2); i++)
            step();
        chk("reach_tc", 8'(m_acc), 8'(TICK - 1));
        ga = 1'b0;
        steps(2);
        chk("tc_no_to", 8'(bus.time_out), 8'd0);
        chk("tc_secs", 8'(bus.secs_left), 8'd1);

        // Async reset mid-run, then no-level start attempt
        lvl = 2'd2;
        ga  = 1'b1;
        steps(7);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0;
        lvl = 2'd0;
        steps(5);
        chk("nolvl_idle", 8'(bus.secs_left), 8'd0);

        // Randomized phase
        ga = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                ga  = 1'b0;
                lvl = 2'($urandom_range(0, 3));
            end else begin
                ga = 1'b1;
            end
            pz = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
